// File: rtl/pattern_player_if.sv
// Stream-side bundle of pattern_player: FWFT FIFO read port and pin-pattern output.
interface pattern_player_if #(
  parameter int W = 16
);
  logic [W-1:0] in_data;
  logic         in_empty;
  logic         in_rd;
  logic [W-1:0] out_data;
  logic         out_strobe;

  modport master (
    input  in_data,
    input  in_empty,
    output in_rd,
    output out_data,
    output out_strobe
  );

  modport slave (
    output in_data,
    output in_empty,
    input  in_rd,
    input  out_data,
    input  out_strobe
  );
endinterface

// File: rtl/pattern_player.sv
// Expands run-length-encoded {value, length-1} word pairs from a FWFT FIFO into a prescaled pin pattern.
// Optional macro PATTERN_PLAYER_STATS_EN adds play_count and underrun_count outputs.
//
// state  | meaning
// F_VAL  | waiting for the value word of the next pair
// F_CNT  | value held, waiting for the run-length word
// F_FULL | complete pair held (nxt_ok), waiting for the output side to load it
// O_IDLE | not playing; out_data holds the last value
// O_RUN  | playing out_data for run+1 ticks
module pattern_player #(
  parameter int           W          = 16,
  parameter logic [W-1:0] IDLE_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  pattern_player_if.master bus,
  input  logic             enable,
  input  logic [15:0]      div,
  input  logic             underrun_clr,
  output logic             running,
  output logic             underrun
`ifdef PATTERN_PLAYER_STATS_EN
  ,output logic [31:0]     play_count
  ,output logic [15:0]     underrun_count
`endif
);

  localparam int CW = 16;

  typedef enum logic [1:0] {F_VAL, F_CNT, F_FULL} fetch_t;
  typedef enum logic       {O_IDLE, O_RUN}        play_t;

  fetch_t          f_state;
  play_t           o_state;
  logic [W-1:0]    nxt_val;
  logic [CW-1:0]   nxt_cnt;
  logic [W-1:0]    out_q;
  logic [CW-1:0]   run;
  logic [15:0]     pre;

  logic nxt_ok;
  logic tick;
  logic run_end;
  logic load;
  logic under_evt;

  assign nxt_ok    = (f_state == F_FULL);
  assign tick      = (pre == div);
  assign run_end   = enable && (o_state == O_RUN) && tick && (run == '0);
  assign load      = enable && nxt_ok && ((o_state == O_IDLE) || run_end);
  assign under_evt = run_end && !nxt_ok;

  assign bus.in_rd      = enable && !bus.in_empty && (f_state != F_FULL);
  assign bus.out_strobe = load;
  assign bus.out_data   = out_q;
  assign running        = (o_state == O_RUN);

  // Only one pair is buffered, so the FIFO is not read again until that pair is loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_state <= F_VAL;
      nxt_val <= '0;
      nxt_cnt <= '0;
    end else begin
      case (f_state)
        F_VAL: begin
          if (bus.in_rd) begin
            nxt_val <= bus.in_data;
            f_state <= F_CNT;
          end
        end
        F_CNT: begin
          if (bus.in_rd) begin
            nxt_cnt <= CW'(bus.in_data);
            f_state <= F_FULL;
          end
        end
        F_FULL: begin
          if (load) f_state <= F_VAL;
        end
        default: f_state <= F_VAL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_state  <= O_IDLE;
      out_q    <= IDLE_VALUE;
      run      <= '0;
      pre      <= '0;
      underrun <= 1'b0;
    end else begin
      if (!enable || (o_state == O_IDLE) || tick) pre <= '0;
      else                                        pre <= pre + 16'd1;

      if (!enable) begin
        o_state <= O_IDLE;
        run     <= '0;
      end else if (load) begin
        out_q   <= nxt_val;
        run     <= nxt_cnt;
        o_state <= O_RUN;
      end else if (under_evt) begin
        o_state <= O_IDLE;
      end else if ((o_state == O_RUN) && tick) begin
        // run_end was false, so run is nonzero here
        run <= run - CW'(1);
      end

      if (under_evt)         underrun <= 1'b1;
      else if (underrun_clr) underrun <= 1'b0;
    end
  end

`ifdef PATTERN_PLAYER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      play_count     <= '0;
      underrun_count <= '0;
    end else begin
      if (enable && (o_state == O_RUN) && tick) play_count <= play_count + 32'd1;
      if (under_evt && (underrun_count != 16'hFFFF)) underrun_count <= underrun_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pattern_player.sv
// Bench for pattern_player: vector table, hand sequences and randomized pairs against a timeline model.
`timescale 1ns/1ps
module tb_pattern_player;
  localparam int W    = 16;
  localparam int MAXC = 512;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        underrun_clr;
  logic [15:0] div;
  logic        running;
  logic        underrun;
`ifdef PATTERN_PLAYER_STATS_EN
  logic [31:0] play_count;
  logic [15:0] underrun_count;
`endif

  pattern_player_if #(.W(W)) bus ();

  pattern_player #(.W(W), .IDLE_VALUE(16'h0000)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .enable(enable),
    .div(div),
    .underrun_clr(underrun_clr),
    .running(running),
    .underrun(underrun)
`ifdef PATTERN_PLAYER_STATS_EN
    ,.play_count(play_count)
    ,.underrun_count(underrun_count)
`endif
  );

  always #5 clk = ~clk;

  // FWFT FIFO model; a reset drops everything not yet read
  logic [15:0] mem [0:1023];
  int head = 0;
  int tail = 0;
  assign bus.in_data  = mem[head[9:0]];
  assign bus.in_empty = (head == tail);
  always @(posedge clk) begin
    if (rst)            head <= tail;
    else if (bus.in_rd) head <= head + 1;
  end

  int checks   = 0;
  int failures = 0;

  logic [15:0] pv [0:7];
  logic [15:0] pc [0:7];
  int          pn;

  logic        tr_rd  [0:MAXC-1];
  logic        tr_stb [0:MAXC-1];
  logic        tr_run [0:MAXC-1];
  logic        tr_und [0:MAXC-1];
  logic [15:0] tr_out [0:MAXC-1];

  logic        ex_rd  [0:MAXC-1];
  logic        ex_stb [0:MAXC-1];
  logic        ex_run [0:MAXC-1];
  logic        ex_und [0:MAXC-1];
  logic [15:0] ex_out [0:MAXC-1];

  typedef struct {
    logic [15:0] v0, c0, v1, c1, v2, c2;
    int          np;
    int          dv;
    int          e_stb;
    int          e_run;
    logic [15:0] e_last;
  } vec_t;
  vec_t tbl [0:4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    mem[tail & 1023] = w;
    tail++;
  endtask

  task automatic do_reset();
    enable       = 1'b0;
    underrun_clr = 1'b0;
    rst          = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Cycle 0 of the trace is the first cycle with enable high.
  task automatic play(input int ncyc);
    do_reset();
    for (int i = 0; i < pn; i++) begin
      push(pv[i]);
      push(pc[i]);
    end
    next_cyc();
    enable = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      tr_rd[c]  = bus.in_rd;
      tr_stb[c] = bus.out_strobe;
      tr_run[c] = running;
      tr_und[c] = underrun;
      tr_out[c] = bus.out_data;
      next_cyc();
    end
  endtask

  // Timeline model: a pair strobes at cycle L, plays ticks over L+1..L+(cnt+1)(div+1);
  // the following pair can be ready no earlier than L+3 (two reads after the load).
  function automatic int build_model(input int dv);
    int L, E, last_e, first_und;
    for (int c = 0; c < MAXC; c++) begin
      ex_rd[c] = 1'b0; ex_stb[c] = 1'b0; ex_run[c] = 1'b0;
      ex_und[c] = 1'b0; ex_out[c] = 16'h0000;
    end
    ex_rd[0] = 1'b1;
    ex_rd[1] = 1'b1;
    L = 2;
    last_e = 0;
    first_und = -1;
    for (int k = 0; k < pn; k++) begin
      ex_stb[L] = 1'b1;
      E = L + (int'(pc[k]) + 1) * (dv + 1);
      for (int c = L + 1; c <= E; c++) ex_run[c] = 1'b1;
      for (int c = L + 1; c < MAXC; c++) ex_out[c] = pv[k];
      if (k + 1 < pn) begin
        ex_rd[L+1] = 1'b1;
        ex_rd[L+2] = 1'b1;
        if (E >= L + 3) L = E;
        else begin
          if (first_und < 0) first_und = E + 1;
          L = L + 3;
        end
      end else if (first_und < 0) begin
        first_und = E + 1;
      end
      last_e = E;
    end
    for (int c = first_und; c < MAXC; c++) ex_und[c] = 1'b1;
    return last_e + 4;
  endfunction

  initial begin
    int n, nstb, nrun, fstb;
`ifdef PATTERN_PLAYER_STATS_EN
    logic [15:0] uc0;
`endif
    rst = 1'b1; enable = 1'b0; underrun_clr = 1'b0; div = 16'd0;

    tbl[0] = '{16'hA5A5, 16'd2, 16'h0000, 16'd0, 16'h0000, 16'd0, 1, 0, 1, 3,  16'hA5A5};
    tbl[1] = '{16'h0001, 16'd0, 16'h0002, 16'd1, 16'h0004, 16'd0, 3, 2, 3, 12, 16'h0004};
    tbl[2] = '{16'hFFFF, 16'd1, 16'h0000, 16'd0, 16'h0000, 16'd0, 1, 3, 1, 8,  16'hFFFF};
    tbl[3] = '{16'h0001, 16'd0, 16'h0002, 16'd1, 16'h0004, 16'd0, 3, 0, 3, 4,  16'h0004};
    tbl[4] = '{16'h1111, 16'd3, 16'h2222, 16'd0, 16'h0000, 16'd0, 2, 1, 2, 10, 16'h2222};

    do_reset();
    @(negedge clk);
    check("rst_out_data", bus.out_data, 16'h0000);
    check("rst_in_rd", bus.in_rd, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_running", running, 1'b0);
    check("rst_strobe", bus.out_strobe, 1'b0);

    for (int t = 0; t < 5; t++) begin
      pv[0] = tbl[t].v0; pc[0] = tbl[t].c0;
      pv[1] = tbl[t].v1; pc[1] = tbl[t].c1;
      pv[2] = tbl[t].v2; pc[2] = tbl[t].c2;
      pn  = tbl[t].np;
      div = 16'(tbl[t].dv);
      play(40);
      nstb = 0; nrun = 0; fstb = -1;
      for (int c = 0; c < 40; c++) begin
        if (tr_stb[c]) begin
          nstb++;
          if (fstb < 0) fstb = c;
        end
        if (tr_run[c]) nrun++;
      end
      check($sformatf("tbl%0d_rd_t0", t), tr_rd[0], 1'b1);
      check($sformatf("tbl%0d_rd_t1", t), tr_rd[1], 1'b1);
      check($sformatf("tbl%0d_first_strobe", t), fstb, 2);
      check($sformatf("tbl%0d_out_t3", t), tr_out[3], tbl[t].v0);
      check($sformatf("tbl%0d_strobes", t), nstb, tbl[t].e_stb);
      check($sformatf("tbl%0d_run_cycles", t), nrun, tbl[t].e_run);
      check($sformatf("tbl%0d_last_out", t), tr_out[39], tbl[t].e_last);
      check($sformatf("tbl%0d_underrun", t), tr_und[39], 1'b1);
    end

    // reset after a finished run returns to idle values
    do_reset();
    @(negedge clk);
    check("rerst_out_data", bus.out_data, 16'h0000);
    check("rerst_underrun", underrun, 1'b0);

    // enable dropped mid-run, then re-enabled with a fresh pair
    pv[0] = 16'h1234; pc[0] = 16'h00FF; pn = 1; div = 16'd0;
    do_reset();
    push(pv[0]); push(pc[0]);
    next_cyc();
    enable = 1'b1;
    repeat (13) next_cyc();
    enable = 1'b0;
    @(negedge clk);
    check("drop_running_same", running, 1'b1);
    check("drop_in_rd_same", bus.in_rd, 1'b0);
    next_cyc();
    push(16'h5678); push(16'h0000);
    @(negedge clk);
    check("drop_running_next", running, 1'b0);
    check("drop_out_hold", bus.out_data, 16'h1234);
    check("drop_in_rd_next", bus.in_rd, 1'b0);
    check("drop_no_underrun", underrun, 1'b0);
    repeat (2) begin
      next_cyc();
      @(negedge clk);
      check("drop_idle_in_rd", bus.in_rd, 1'b0);
    end
    next_cyc();
    enable = 1'b1;
    @(negedge clk);
    check("reen_rd_r0", bus.in_rd, 1'b1);
    next_cyc(); @(negedge clk);
    check("reen_rd_r1", bus.in_rd, 1'b1);
    next_cyc(); @(negedge clk);
    check("reen_strobe_r2", bus.out_strobe, 1'b1);
    check("reen_running_r2", running, 1'b0);
    next_cyc(); @(negedge clk);
    check("reen_out_r3", bus.out_data, 16'h5678);
    check("reen_running_r3", running, 1'b1);
    next_cyc(); @(negedge clk);
    check("reen_running_r4", running, 1'b0);
    check("reen_underrun_r4", underrun, 1'b1);
    check("reen_out_r4", bus.out_data, 16'h5678);

    // underrun set and clear in the same cycle, then clear alone
    pv[0] = 16'h0001; pc[0] = 16'h0000; div = 16'd0;
    do_reset();
    push(pv[0]); push(pc[0]);
`ifdef PATTERN_PLAYER_STATS_EN
    uc0 = underrun_count;
`endif
    next_cyc();
    enable = 1'b1;
    repeat (3) next_cyc();
    underrun_clr = 1'b1;
    @(negedge clk);
    check("clr_running_e", running, 1'b1);
    next_cyc(); @(negedge clk);
    check("clr_set_priority", underrun, 1'b1);
    next_cyc();
    underrun_clr = 1'b0;
    @(negedge clk);
    check("clr_alone", underrun, 1'b0);
`ifdef PATTERN_PLAYER_STATS_EN
    check("stats_underrun_count", underrun_count, uc0 + 16'd1);
    check("stats_play_count", play_count, 32'd1);
`endif

    // randomized pairs against the timeline model
    for (int it = 0; it < 20; it++) begin
      pn  = $urandom_range(1, 5);
      div = 16'($urandom_range(0, 3));
      for (int k = 0; k < pn; k++) begin
        pv[k] = 16'($urandom);
        pc[k] = 16'($urandom_range(0, 6));
      end
      n = build_model(int'(div));
      play(n);
      for (int c = 0; c < n; c++) begin
        check($sformatf("rnd%0d_rd_c%0d", it, c), tr_rd[c], ex_rd[c]);
        check($sformatf("rnd%0d_strobe_c%0d", it, c), tr_stb[c], ex_stb[c]);
        check($sformatf("rnd%0d_running_c%0d", it, c), tr_run[c], ex_run[c]);
        check($sformatf("rnd%0d_underrun_c%0d", it, c), tr_und[c], ex_und[c]);
        check($sformatf("rnd%0d_out_c%0d", it, c), tr_out[c], ex_out[c]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
